// File: rtl/cubehash_core_arbiter.sv
// Two-requester arbiter in front of one shared CubeHash core.
// A requester owns the core from first grant until done, abort or reset.
`timescale 1ns/1ps
module cubehash_core_arbiter #(
  parameter int STREAM_TO = 64,
  parameter int FINAL_TO  = 200
) (
  input  logic         clk,
  input  logic         rst_p,
  input  logic         req0_valid,
  input  logic         req0_last,
  input  logic [255:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic         req1_last,
  input  logic [255:0] req1_data,
  output logic         req1_ready,
  output logic         done0,
  output logic         done1,
  output logic         err0,
  output logic         err1,
  output logic         core_blk_valid,
  output logic         core_blk_last,
  output logic [255:0] core_blk_data,
  input  logic         core_blk_ready,
  input  logic         core_hash_done,
  output logic         core_abort,
  output logic [1:0]   grant,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINAL,
    ABORT
  } state_t;

  localparam logic [7:0] STREAM_LAST = 8'(STREAM_TO - 1);
  localparam logic [7:0] FINAL_LAST  = 8'(FINAL_TO - 1);

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [7:0] wd_q, wd_d;
  logic       lo_q, lo_d;
  logic [1:0] done_q, done_d;
  logic [1:0] err_q, err_d;
  logic       abort_q, abort_d;

  logic         in_stream;
  logic         own_valid;
  logic         own_last;
  logic [255:0] own_data;
  logic         xfer;
  logic         pick1;

  assign in_stream = (state_q == STREAM);

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    unique case (1'b1)
      grant_q[0]: begin
        own_valid = req0_valid;
        own_last  = req0_last;
        own_data  = req0_data;
      end
      grant_q[1]: begin
        own_valid = req1_valid;
        own_last  = req1_last;
        own_data  = req1_data;
      end
      default: ;
    endcase
  end

  assign core_blk_valid = in_stream & own_valid;
  assign core_blk_last  = in_stream & own_last;
  assign core_blk_data  = own_data;

  assign req0_ready = core_blk_ready & grant_q[0] & in_stream;
  assign req1_ready = core_blk_ready & grant_q[1] & in_stream;

  assign xfer = core_blk_valid & core_blk_ready;

  // On a tie the requester that did not own the core last time wins.
  assign pick1 = req1_valid & (~req0_valid | ~lo_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wd_d    = wd_q;
    lo_d    = lo_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        wd_d    = '0;
        if (req0_valid | req1_valid) begin
          state_d = STREAM;
          grant_d = pick1 ? 2'b10 : 2'b01;
          lo_d    = pick1;
        end
      end
      STREAM: begin
        if (xfer) begin
          wd_d = '0;
          if (core_blk_last) state_d = FINAL;
        end else if (wd_q == STREAM_LAST) begin
          state_d = ABORT;
          wd_d    = '0;
          abort_d = 1'b1;
          err_d   = grant_q;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      FINAL: begin
        if (core_hash_done) begin
          state_d = IDLE;
          grant_d = 2'b00;
          wd_d    = '0;
          done_d  = grant_q;
        end else if (wd_q == FINAL_LAST) begin
          state_d = ABORT;
          wd_d    = '0;
          abort_d = 1'b1;
          err_d   = grant_q;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = 2'b00;
        wd_d    = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
        wd_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      wd_q    <= '0;
      lo_q    <= 1'b1;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wd_q    <= wd_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign done0      = done_q[0];
  assign done1      = done_q[1];
  assign err0       = err_q[0];
  assign err1       = err_q[1];
  assign core_abort = abort_q;
  assign grant      = grant_q;
  assign busy       = |grant_q;

endmodule

// File: tb/tb_cubehash_core_arbiter.sv
// Scoreboard bench for cubehash_core_arbiter: stimulus queues expected
// transfers/done/err events, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_cubehash_core_arbiter;

  localparam int XFER = 0;
  localparam int DONE = 1;
  localparam int ERR  = 2;

  typedef struct {
    int           kind;
    bit           src;
    logic [255:0] data;
    bit           last;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_p;
  logic         req0_valid, req0_last, req0_ready;
  logic [255:0] req0_data;
  logic         req1_valid, req1_last, req1_ready;
  logic [255:0] req1_data;
  logic         done0, done1, err0, err1;
  logic         core_blk_valid, core_blk_last;
  logic [255:0] core_blk_data;
  logic         core_blk_ready, core_hash_done, core_abort;
  logic [1:0]   grant;
  logic         busy;

  int  n_checks = 0;
  int  n_fail = 0;
  ev_t sb[$];

  localparam logic [255:0] D0 = {8{32'hA0A0_0000}};
  localparam logic [255:0] D1 = {8{32'hA1A1_1111}};
  localparam logic [255:0] D2 = {8{32'hA2A2_2222}};
  localparam logic [255:0] D3 = {8{32'hA3A3_3333}};
  localparam logic [255:0] D4 = {8{32'hA4A4_4444}};
  localparam logic [255:0] D5 = {8{32'hA5A5_5555}};
  localparam logic [255:0] E0 = {8{32'hB0B0_0000}};
  localparam logic [255:0] E1 = {8{32'hB1B1_1111}};
  localparam logic [255:0] E2 = {8{32'hB2B2_2222}};
  localparam logic [255:0] E3 = {8{32'hB3B3_3333}};

  cubehash_core_arbiter #(.STREAM_TO(64), .FINAL_TO(200)) dut (
    .clk(clk), .rst_p(rst_p),
    .req0_valid(req0_valid), .req0_last(req0_last),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_last(req1_last),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .core_blk_valid(core_blk_valid), .core_blk_last(core_blk_last),
    .core_blk_data(core_blk_data), .core_blk_ready(core_blk_ready),
    .core_hash_done(core_hash_done), .core_abort(core_abort),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic string kname(input int k);
    return (k == XFER) ? "xfer" : (k == DONE) ? "done" : "err";
  endfunction

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input int kind, input bit src,
                          input logic [255:0] data, input bit last);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: unexpected %s from req%0d at %0t",
               kname(kind), src, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.src != src ||
          (kind == XFER && (e.data !== data || e.last != last))) begin
        n_fail++;
        $display("FAIL scoreboard: got %s req%0d %h last %0d, required %s req%0d %h last %0d",
                 kname(kind), src, data, last,
                 kname(e.kind), e.src, e.data, e.last);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_p) begin
      if (core_blk_valid && core_blk_ready)
        sb_check(XFER, grant[1], core_blk_data, core_blk_last);
      if (done0 || done1)
        sb_check(DONE, done1, '0, 1'b0);
      if (err0 || err1) begin
        sb_check(ERR, err1, '0, 1'b0);
        chk("abort_with_err", core_abort, 1'b1);
      end else if (core_abort) begin
        chk("abort_without_err", core_abort, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input bit src,
                         input logic [255:0] d, input bit l);
    ev_t e;
    e.kind = kind;
    e.src  = src;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic send_block(input bit src, input logic [255:0] d,
                            input bit l);
    bit got;
    got = 1'b0;
    if (src) begin
      req1_valid = 1'b1; req1_data = d; req1_last = l;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_last = l;
    end
    push_ev(XFER, src, d, l);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (src ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("xfer_accepted", got, 1'b1);
    tick();
    if (src) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic hash_done_pulse(input bit src, input bit expect_done);
    core_hash_done = 1'b1;
    if (expect_done) push_ev(DONE, src, '0, 1'b0);
    tick();
    core_hash_done = 1'b0;
  endtask

  initial begin
    int k;
    rst_p = 1'b1;
    req0_valid = 0; req0_last = 0; req0_data = '0;
    req1_valid = 0; req1_last = 0; req1_data = '0;
    core_blk_ready = 0; core_hash_done = 0;
    #1;
    chk("reset_grant", grant, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_blk_valid", core_blk_valid, 1'b0);
    chk("reset_blk_data", core_blk_data, '0);
    chk("reset_abort", core_abort, 1'b0);
    chk("reset_done_err", {done0, done1, err0, err1}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_p = 1'b0;

    // Tie after reset goes to req0; req1 waits for the whole message.
    core_blk_ready = 1'b1;
    req0_valid = 1; req0_data = D0; req0_last = 0;
    req1_valid = 1; req1_data = E0; req1_last = 0;
    tick();
    chk("tie_after_reset_grant", grant, 2'b01);
    chk("tie_busy", busy, 1'b1);
    send_block(0, D0, 0);
    send_block(0, D1, 0);
    send_block(0, D2, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("final_req1_ready_low", req1_ready, 1'b0);
      chk("final_grant_held", grant, 2'b01);
    end
    tick();
    hash_done_pulse(0, 1);
    chk("done0_pulse", done0, 1'b1);
    chk("idle_grant_after_done", grant, 2'b00);
    tick();
    chk("req1_granted", grant, 2'b10);
    send_block(1, E0, 1);
    tick();
    hash_done_pulse(1, 1);
    chk("done1_pulse", done1, 1'b1);
    tick();

    // Stream watchdog: one block, then silence.
    send_block(0, D3, 0);
    push_ev(ERR, 0, '0, 1'b0);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      k++;
      if (err0) break;
    end
    chk("stream_abort_cycle", k, 64);
    chk("stream_abort_pulse", core_abort, 1'b1);
    tick();
    chk("grant_after_stream_abort", grant, 2'b00);
    chk("err0_single_cycle", err0, 1'b0);

    // Stalled core with tie pending: req1 wins since req0 owned last.
    core_blk_ready = 1'b0;
    req0_valid = 1; req0_data = D4; req0_last = 1;
    req1_valid = 1; req1_data = E1; req1_last = 0;
    tick();
    chk("tie_after_req0_grant", grant, 2'b10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_blk_valid", core_blk_valid, 1'b1);
      chk("stall_blk_data", core_blk_data, E1);
      chk("stall_ready_low", req1_ready, 1'b0);
    end
    tick();
    core_blk_ready = 1'b1;
    send_block(1, E1, 0);
    send_block(1, E2, 1);
    hash_done_pulse(1, 1);

    // Final watchdog expires with req0's last block outstanding.
    send_block(0, D4, 1);
    push_ev(ERR, 0, '0, 1'b0);
    k = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      k++;
      if (err0) break;
    end
    chk("final_abort_cycle", k, 200);
    tick();
    chk("grant_after_final_abort", grant, 2'b00);

    // core_hash_done on the very last cycle beats the timeout.
    send_block(0, D5, 1);
    repeat (199) @(posedge clk);
    #1;
    hash_done_pulse(0, 1);
    chk("late_done0", done0, 1'b1);
    chk("late_no_err0", err0, 1'b0);
    tick();

    // Reset mid-FINAL: no abort, spurious done ignored.
    send_block(1, E3, 1);
    tick();
    #3 rst_p = 1'b1;
    #1;
    chk("async_reset_grant", grant, 2'b00);
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_no_abort", core_abort, 1'b0);
    @(posedge clk);
    #1 rst_p = 1'b0;
    hash_done_pulse(1, 0);
    chk("spurious_done_ignored", {done0, done1}, 2'b00);
    chk("spurious_done_grant", grant, 2'b00);
    tick();

    // Reset restores req0 as the tie winner.
    core_blk_ready = 1'b0;
    req0_valid = 1; req1_valid = 1;
    tick();
    chk("tie_after_midreset", grant, 2'b01);
    req0_valid = 0; req1_valid = 0;
    rst_p = 1'b1;
    tick();
    rst_p = 1'b0;
    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
